// File: rtl/systolic_pkg.sv
// Shared types and index helpers for the NxN systolic array.
// Index helpers map matrix coordinates onto the flattened buses.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Cycles needed after the last beat for the far corner to finish
  function automatic int drain_cycles(int n);
    return 2 * n - 2;
  endfunction

  // LSB of operand idx on an a_col / b_row bus
  function automatic int op_lsb(int idx, int dw);
    return idx * dw;
  endfunction

  // LSB of C[i][j] on the flattened result bus
  function automatic int c_lsb(int i, int j, int n, int aw);
    return (i * n + j) * aw;
  endfunction

endpackage

// File: rtl/pe_mac_acc.sv
// One output-stationary processing element: multiply-accumulate
// on every array advance, forwarding a right and b down.
module pe_mac_acc #(
  parameter int DW = 8,
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  input  logic          clr,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [AW-1:0] acc
);

  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [AW-1:0]   acc_q;
  logic [2*DW-1:0] prod;

  assign prod = in_a * in_b;

  // Accumulate and forward operands only when the array advances
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      if (clr) begin
        acc_q <= '0;
      end else if (adv) begin
        acc_q <= acc_q + AW'(prod);
      end
      if (adv) begin
        a_q <= in_a;
        b_q <= in_b;
      end
    end
  end

  assign out_a = a_q;
  assign out_b = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_nxn.sv
// NxN output-stationary systolic matrix multiplier with input
// skew chains, stall-tolerant load and a fixed-length drain.
module systolic_array_nxn
  import systolic_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 2 * DW + $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              acc_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   a_col,
  input  logic [N*DW-1:0]   b_row,
  output logic              busy,
  output logic              done,
  output logic              c_valid,
  output logic [N*N*AW-1:0] c
);

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] LAST_K = CW'(N - 1);
  localparam logic [CW-1:0] LAST_D = CW'(drain_cycles(N) - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q;
  logic          busy_q;
  logic          done_q;
  logic          c_valid_q;

  logic load;
  logic adv;
  logic clr;

  assign load = (state_q == ST_LOAD);
  assign adv  = (load && in_valid) || (state_q == ST_DRAIN);
  assign clr  = (state_q == ST_IDLE) && start && !acc_en;

  // Job sequencing with registered handshake/status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      c_valid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_LOAD;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            c_valid_q  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (cnt_q == LAST_K) begin
              state_q    <= ST_DRAIN;
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (cnt_q == LAST_D) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            c_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign c_valid  = c_valid_q;

  logic [DW-1:0] a_in [N];
  logic [DW-1:0] b_in [N];
  logic [DW-1:0] a_sk [N];
  logic [DW-1:0] b_sk [N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    assign a_in[i] = load ? a_col[op_lsb(i, DW) +: DW] : '0;
    assign b_in[i] = load ? b_row[op_lsb(i, DW) +: DW] : '0;

    if (i == 0) begin : g_s0
      assign a_sk[i] = a_in[i];
      assign b_sk[i] = b_in[i];
    end else begin : g_sn
      logic [DW-1:0] sa_q [i];
      logic [DW-1:0] sb_q [i];

      // Delay line of depth i, shifting only on array advance
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < i; s++) begin
            sa_q[s] <= '0;
            sb_q[s] <= '0;
          end
        end else if (adv) begin
          sa_q[0] <= a_in[i];
          sb_q[0] <= b_in[i];
          for (int s = 1; s < i; s++) begin
            sa_q[s] <= sa_q[s-1];
            sb_q[s] <= sb_q[s-1];
          end
        end
      end

      assign a_sk[i] = sa_q[i-1];
      assign b_sk[i] = sb_q[i-1];
    end
  end

  logic [DW-1:0]   pa  [N][N];
  logic [DW-1:0]   pb  [N][N];
  logic [AW-1:0]   acc [N][N];
  logic [N*DW-1:0] unused_a;
  logic [N*DW-1:0] unused_b;

  for (genvar i = 0; i < N; i++) begin : g_row
    assign unused_a[op_lsb(i, DW) +: DW] = pa[i][N-1];
    assign unused_b[op_lsb(i, DW) +: DW] = pb[N-1][i];

    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] ia;
      logic [DW-1:0] ib;

      if (j == 0) begin : g_ae
        assign ia = a_sk[i];
      end else begin : g_ai
        assign ia = pa[i][j-1];
      end

      if (i == 0) begin : g_be
        assign ib = b_sk[j];
      end else begin : g_bi
        assign ib = pb[i-1][j];
      end

      pe_mac_acc #(
        .DW (DW),
        .AW (AW)
      ) u_pe (
        .clk   (clk),
        .reset (reset),
        .adv   (adv),
        .clr   (clr),
        .in_a  (ia),
        .in_b  (ib),
        .out_a (pa[i][j]),
        .out_b (pb[i][j]),
        .acc   (acc[i][j])
      );

      assign c[c_lsb(i, j, N, AW) +: AW] = acc[i][j];
    end
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Randomised scoreboard bench for systolic_array_nxn:
// a 2x2 (AW=8) and a 4x4 instance against a matrix model.
module tb_systolic_array_nxn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        rst2, st2, ae2, iv2;
  logic [15:0] a2, b2;
  logic        rdy2, bsy2, dn2, cv2;
  logic [31:0] c2;

  logic         rst4, st4, ae4, iv4;
  logic [31:0]  a4, b4;
  logic         rdy4, bsy4, dn4, cv4;
  logic [287:0] c4;

  systolic_array_nxn #(.N(2), .DW(8), .AW(8)) u_d2 (
    .clk      (clk),
    .reset    (rst2),
    .start    (st2),
    .acc_en   (ae2),
    .in_valid (iv2),
    .in_ready (rdy2),
    .a_col    (a2),
    .b_row    (b2),
    .busy     (bsy2),
    .done     (dn2),
    .c_valid  (cv2),
    .c        (c2)
  );

  systolic_array_nxn #(.N(4), .DW(8)) u_d4 (
    .clk      (clk),
    .reset    (rst4),
    .start    (st4),
    .acc_en   (ae4),
    .in_valid (iv4),
    .in_ready (rdy4),
    .a_col    (a4),
    .b_row    (b4),
    .busy     (bsy4),
    .done     (dn4),
    .c_valid  (cv4),
    .c        (c4)
  );

  int     tA [4][4];
  int     tB [4][4];
  longint mdl [2][4][4];

  logic [287:0] q2 [$];
  logic [287:0] q4 [$];
  logic [287:0] ex2, ex4;

  task automatic chk(bit ok, string nm,
                     logic [287:0] act, logic [287:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic rdy_f(int d);
    return d != 0 ? rdy4 : rdy2;
  endfunction
  function automatic logic bsy_f(int d);
    return d != 0 ? bsy4 : bsy2;
  endfunction
  function automatic logic dn_f(int d);
    return d != 0 ? dn4 : dn2;
  endfunction
  function automatic logic cv_f(int d);
    return d != 0 ? cv4 : cv2;
  endfunction
  function automatic logic [287:0] c_f(int d);
    return d != 0 ? c4 : {256'd0, c2};
  endfunction

  task automatic set_in(int d, logic s, logic ae, logic iv,
                        logic [31:0] av, logic [31:0] bv);
    if (d != 0) begin
      st4 = s; ae4 = ae; iv4 = iv; a4 = av; b4 = bv;
    end else begin
      st2 = s; ae2 = ae; iv2 = iv; a2 = av[15:0]; b2 = bv[15:0];
    end
  endtask

  task automatic rst_set(int d, logic v);
    if (d != 0) rst4 = v;
    else        rst2 = v;
  endtask

  // Expected C bus from the model, wrapped to AW bits
  function automatic logic [287:0] pack_c(int d);
    logic [287:0] v;
    longint t;
    int n, aw;
    v  = '0;
    n  = d != 0 ? 4 : 2;
    aw = d != 0 ? 18 : 8;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        t = mdl[d][i][j];
        for (int b = 0; b < aw; b++) v[(i*n+j)*aw + b] = t[b];
      end
    return v;
  endfunction

  // Scoreboard monitor: every done pops one expected result
  always @(negedge clk) begin
    if (rst2 && dn2) begin
      if (q2.size() == 0) chk(0, "unexp_done2", 1, 0);
      else begin
        ex2 = q2.pop_front();
        chk(c_f(0) == ex2, "c_n2", c_f(0), ex2);
        chk(cv2 == 1'b1, "cv_at_done2", cv2, 1);
      end
    end
    if (rst4 && dn4) begin
      if (q4.size() == 0) chk(0, "unexp_done4", 1, 0);
      else begin
        ex4 = q4.pop_front();
        chk(c_f(1) == ex4, "c_n4", c_f(1), ex4);
        chk(cv4 == 1'b1, "cv_at_done4", cv4, 1);
      end
    end
  end

  // mode: 0 random, 1 fixed 2x2 example, 2 all 255, 3 identity
  task automatic job(int d, bit acc, int mode, int stalls,
                     bit glitch, bit abort);
    int n, aw, k, g, st_left, first, stl_after;
    longint s, mask;
    bit stall, rd_bad;
    logic [31:0] av, bv;
    logic [287:0] expv;
    n     = d != 0 ? 4 : 2;
    aw    = d != 0 ? 18 : 8;
    mask  = (longint'(1) << aw) - 1;
    first = 0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        case (mode)
          1: begin tA[i][j] = 2*i + j + 1; tB[i][j] = 2*i + j + 5; end
          2: begin tA[i][j] = 255; tB[i][j] = 255; end
          3: begin tA[i][j] = (i == j) ? 1 : 0; tB[i][j] = 4*i + j; end
          default: begin
            tA[i][j] = $urandom_range(0, 255);
            tB[i][j] = $urandom_range(0, 255);
          end
        endcase
      end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int kk = 0; kk < n; kk++) s += tA[i][kk] * tB[kk][j];
        mdl[d][i][j] = ((acc ? mdl[d][i][j] : 0) + s) & mask;
      end
    expv = pack_c(d);
    if (!abort) begin
      if (d != 0) q4.push_back(expv);
      else        q2.push_back(expv);
    end

    if (glitch) begin
      set_in(d, 0, 1, 1, $urandom, $urandom);
      repeat (2) @(negedge clk);
    end
    set_in(d, 1, acc, 0, 0, 0);
    @(negedge clk);
    chk(cv_f(d) == 1'b0, "cv_drop", cv_f(d), 0);
    chk(rdy_f(d) == 1'b1, "rdy_load", rdy_f(d), 1);

    k = 0; g = 0; st_left = stalls; stl_after = 0;
    while (k < n && g < 100) begin
      g++;
      stall = (k > 0) && (st_left > 0) &&
              ($urandom_range(0, 1) == 1 || st_left >= n - k);
      if (stall) begin
        st_left--;
        stl_after++;
        set_in(d, 0, acc, 0, $urandom, $urandom);
      end else begin
        av = '0; bv = '0;
        for (int i = 0; i < n; i++) begin
          av[i*8 +: 8] = 8'(tA[i][k]);
          bv[i*8 +: 8] = 8'(tB[k][i]);
        end
        set_in(d, glitch && k == 1, ~acc, 1, av, bv);
        if (rdy_f(d)) begin
          if (k == 0) first = cyc;
          k++;
        end
      end
      @(negedge clk);
    end
    if (k < n) chk(0, "accept_timeout", k, n);

    if (glitch) set_in(d, 1, ~acc, 1, $urandom, $urandom);
    else        set_in(d, 0, acc, 0, 0, 0);

    if (abort) begin
      @(negedge clk);
      set_in(d, 0, 0, 0, 0, 0);
      rst_set(d, 0);
      #1;
      chk(bsy_f(d) == 1'b0, "abort_busy", bsy_f(d), 0);
      chk(dn_f(d) == 1'b0, "abort_done", dn_f(d), 0);
      chk(cv_f(d) == 1'b0, "abort_cv", cv_f(d), 0);
      chk(c_f(d) == '0, "abort_c", c_f(d), 0);
      @(negedge clk);
      rst_set(d, 1);
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) mdl[d][i][j] = 0;
      return;
    end

    rd_bad = 0; g = 0;
    while (!dn_f(d) && g < 100) begin
      if (rdy_f(d)) rd_bad = 1;
      @(negedge clk);
      set_in(d, 0, acc, 0, 0, 0);
      g++;
    end
    chk(!rd_bad, "rdy_in_drain", rd_bad, 0);
    if (g >= 100) chk(0, "done_timeout", g, 0);
    else chk(cyc == first + 3*n - 2 + stl_after, "latency",
             cyc - first, 3*n - 2 + stl_after);
    @(negedge clk);
    chk(dn_f(d) == 1'b0, "done_pulse", dn_f(d), 0);
    chk(cv_f(d) == 1'b1, "cv_hold", cv_f(d), 1);
    chk(c_f(d) == expv, "c_hold", c_f(d), expv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    rst2 = 1'b1; rst4 = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) mdl[d][i][j] = 0;
    #2;
    rst2 = 1'b0; rst4 = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(rdy_f(d) == 1'b0, "rst_rdy", rdy_f(d), 0);
      chk(bsy_f(d) == 1'b0, "rst_busy", bsy_f(d), 0);
      chk(dn_f(d) == 1'b0, "rst_done", dn_f(d), 0);
      chk(cv_f(d) == 1'b0, "rst_cv", cv_f(d), 0);
      chk(c_f(d) == '0, "rst_c", c_f(d), 0);
    end
    repeat (2) @(negedge clk);
    rst2 = 1'b1; rst4 = 1'b1;
    @(negedge clk);

    job(0, 0, 1, 0, 0, 0);
    job(0, 1, 1, 0, 0, 0);
    job(0, 0, 1, 0, 0, 0);
    job(0, 0, 2, 0, 0, 0);
    for (int r = 0; r < 3; r++)
      job(0, 1'($urandom_range(0, 1)), 0, $urandom_range(0, 2), 0, 0);

    job(1, 0, 3, 3, 0, 0);
    job(1, 0, 0, 0, 0, 1);
    job(1, 1, 0, 0, 0, 0);
    job(1, 0, 0, 2, 1, 0);
    for (int r = 0; r < 4; r++)
      job(1, 1'($urandom_range(0, 1)), 0, $urandom_range(0, 3),
          r == 2, 0);

    repeat (3) @(negedge clk);
    chk(q2.size() == 0, "q2_empty", q2.size(), 0);
    chk(q4.size() == 0, "q4_empty", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
